// File: rtl/freq_calc.sv
// freq_calc: converts a gate count pair into f_meas = F_REF_HZ * meas_cnt / ref_cnt (Hz) with a restoring divider
//   Optional feature macro FREQ_CALC_ROUND_EN: round-to-nearest (ties up) instead of floor.
//   Ports:
//     clk_ref    in   reference clock (only clock)
//     sys_rst    in   asynchronous active-high reset
//     cnt_valid  in   strobe: ref_cnt/meas_cnt hold a completed gate
//     ref_cnt    in   reference-clock cycles in the gate (divisor)
//     meas_cnt   in   measured-clock edges in the gate
//     busy       out  calculation in progress
//     freq_valid out  strobe: freq_out and flags updated
//     freq_out   out  frequency in Hz, saturated to OUT_W bits
//     overflow   out  quotient exceeded OUT_W bits
//     div_err    out  ref_cnt was zero
//     drop       out  pulse: cnt_valid arrived while busy and was ignored
module freq_calc #(
    parameter int unsigned F_REF_HZ = 10_000_000,
    parameter int          CNT_W    = 32,
    parameter int          OUT_W    = 32
) (
    input  logic             clk_ref,
    input  logic             sys_rst,
    input  logic             cnt_valid,
    input  logic [CNT_W-1:0] ref_cnt,
    input  logic [CNT_W-1:0] meas_cnt,
    output logic             busy,
    output logic             freq_valid,
    output logic [OUT_W-1:0] freq_out,
    output logic             overflow,
    output logic             div_err,
    output logic             drop
);
    localparam int NW = 2 * CNT_W;
    localparam int CW = $clog2(NW + 1);
    localparam logic [NW-1:0] F_REF = NW'(F_REF_HZ);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] d_q, m_q;
    logic [NW-1:0]    n_q, q_q;
    logic [CNT_W:0]   r_q, r_d;
    logic [CW-1:0]    cnt_q;
    logic             err_q, sat_q;
    logic             busy_q, freq_valid_q, overflow_q, div_err_q, drop_q;
    logic [OUT_W-1:0] freq_out_q;
    logic [CNT_W+1:0] r_sh;
    logic [CNT_W:0]   r_diff;
    logic             ge;
    logic [NW-1:0]    prod_d;
    logic             carry;

`ifdef FREQ_CALC_ROUND_EN
    // Adding half the divisor before a floor division rounds to nearest, ties up.
    logic [NW:0] sum_d;
    assign sum_d  = {1'b0, F_REF * {{CNT_W{1'b0}}, m_q}} + {{(CNT_W + 2){1'b0}}, d_q[CNT_W-1:1]};
    assign prod_d = sum_d[NW-1:0];
    assign carry  = sum_d[NW];
`else
    assign prod_d = F_REF * {{CNT_W{1'b0}}, m_q};
    assign carry  = 1'b0;
`endif

    // Restoring step: R stays below D, so R' < 2D and the difference fits CNT_W+1 bits.
    always_comb begin
        r_sh   = {r_q, n_q[NW-1]};
        ge     = r_sh >= {2'b00, d_q};
        r_diff = r_sh[CNT_W:0] - {1'b0, d_q};
        r_d    = ge ? r_diff : r_sh[CNT_W:0];
    end

    always_ff @(posedge clk_ref or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            d_q          <= '0;
            m_q          <= '0;
            n_q          <= '0;
            q_q          <= '0;
            r_q          <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            sat_q        <= 1'b0;
            busy_q       <= 1'b0;
            freq_valid_q <= 1'b0;
            freq_out_q   <= '0;
            overflow_q   <= 1'b0;
            div_err_q    <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            freq_valid_q <= 1'b0;
            drop_q       <= cnt_valid && state_q != IDLE;
            case (state_q)
                IDLE: if (cnt_valid) begin
                    d_q     <= ref_cnt;
                    m_q     <= meas_cnt;
                    busy_q  <= 1'b1;
                    err_q   <= ref_cnt == '0;
                    state_q <= ref_cnt == '0 ? DONE : MUL;
                end
                MUL: begin
                    n_q     <= prod_d;
                    r_q     <= '0;
                    q_q     <= '0;
                    cnt_q   <= CW'(NW);
                    sat_q   <= carry;
                    state_q <= carry ? DONE : DIV;
                end
                DIV: begin
                    n_q     <= n_q << 1;
                    r_q     <= r_d;
                    q_q     <= {q_q[NW-2:0], ge};
                    cnt_q   <= cnt_q - 1'b1;
                    state_q <= cnt_q == CW'(1) ? DONE : DIV;
                end
                default: begin
                    freq_valid_q <= 1'b1;
                    busy_q       <= 1'b0;
                    freq_out_q   <= (err_q || sat_q || |q_q[NW-1:OUT_W]) ? '1 : q_q[OUT_W-1:0];
                    overflow_q   <= !err_q && (sat_q || |q_q[NW-1:OUT_W]);
                    div_err_q    <= err_q;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign freq_valid = freq_valid_q;
    assign freq_out   = freq_out_q;
    assign overflow   = overflow_q;
    assign div_err    = div_err_q;
    assign drop       = drop_q;
endmodule

// File: tb/tb_freq_calc.sv
// tb_freq_calc: scoreboard bench for freq_calc with directed vectors
module tb_freq_calc;
    logic        clk_ref = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cnt_valid = 1'b0;
    logic [31:0] ref_cnt = '0;
    logic [31:0] meas_cnt = '0;
    logic        busy, freq_valid, overflow, div_err, drop;
    logic [31:0] freq_out;

    typedef struct {
        logic [31:0] freq;
        logic        ovf;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   drops = 0;
    int   valids = 0;

`ifdef FREQ_CALC_ROUND_EN
    localparam logic [31:0] R32 = 32'd6_666_667;
    localparam logic [31:0] R61 = 32'd1_666_667;
`else
    localparam logic [31:0] R32 = 32'd6_666_666;
    localparam logic [31:0] R61 = 32'd1_666_666;
`endif

    freq_calc #(.F_REF_HZ(10_000_000), .CNT_W(32), .OUT_W(32)) dut (
        .clk_ref(clk_ref), .sys_rst(sys_rst), .cnt_valid(cnt_valid),
        .ref_cnt(ref_cnt), .meas_cnt(meas_cnt), .busy(busy),
        .freq_valid(freq_valid), .freq_out(freq_out), .overflow(overflow),
        .div_err(div_err), .drop(drop)
    );

    always #5 clk_ref = ~clk_ref;
    always @(posedge clk_ref) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk_ref) begin
        if (!sys_rst) begin
            if (drop) drops++;
            if (freq_valid) begin
                valids++;
                if (sb.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("freq_out", 64'(freq_out), 64'(e.freq));
                    chk("overflow", 64'(overflow), 64'(e.ovf));
                    chk("div_err", 64'(div_err), 64'(e.err));
                    chk("latency_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic send(input logic [31:0] r, input logic [31:0] m, input logic [31:0] f,
                        input logic ovf, input logic err, input int lat);
        exp_t e;
        @(negedge clk_ref);
        ref_cnt = r;
        meas_cnt = m;
        cnt_valid = 1'b1;
        @(posedge clk_ref);
        #1;
        cnt_valid = 1'b0;
        ref_cnt = $urandom;
        meas_cnt = $urandom;
        e.freq = f;
        e.ovf = ovf;
        e.err = err;
        e.cyc = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk_ref);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk_ref);
    endtask

    initial begin
        repeat (3) @(posedge clk_ref);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(freq_valid), 64'd0);
        chk("rst_freq", 64'(freq_out), 64'd0);
        chk("rst_flags", 64'({overflow, div_err, drop}), 64'd0);
        @(negedge clk_ref);
        sys_rst = 1'b0;

        send(32'd10_000_000, 32'd1_000_000, 32'd1_000_000, 1'b0, 1'b0, 66);
        @(posedge clk_ref); #1;
        chk("busy_k1", 64'(busy), 64'd1);
        repeat (64) @(posedge clk_ref);
        #1;
        chk("busy_k65", 64'(busy), 64'd1);
        @(posedge clk_ref); #1;
        chk("busy_k66", 64'(busy), 64'd0);
        drain();

        send(32'd3, 32'd2, R32, 1'b0, 1'b0, 66);
        drain();
        send(32'd6, 32'd1, R61, 1'b0, 1'b0, 66);
        drain();
        send(32'd1000, 32'd333, 32'd3_330_000, 1'b0, 1'b0, 66);
        drain();
        send(32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 66);
        drain();
        send(32'd10_000_000, 32'd5, 32'd5, 1'b0, 1'b0, 66);
        drain();
        send(32'd0, 32'd123, 32'hFFFF_FFFF, 1'b0, 1'b1, 1);
        drain();
        chk("hold_freq", 64'(freq_out), 64'hFFFF_FFFF);
        chk("hold_err", 64'(div_err), 64'd1);
        send(32'd10_000_000, 32'd7, 32'd7, 1'b0, 1'b0, 66);
        drain();
        send(32'd12345, 32'd0, 32'd0, 1'b0, 1'b0, 66);
        drain();

        drops = 0;
        valids = 0;
        send(32'd10_000_000, 32'd2_000_000, 32'd2_000_000, 1'b0, 1'b0, 66);
        repeat (9) @(posedge clk_ref);
        @(negedge clk_ref);
        ref_cnt = 32'd5;
        meas_cnt = 32'd5;
        cnt_valid = 1'b1;
        @(posedge clk_ref); #1;
        cnt_valid = 1'b0;
        chk("drop_pulse", 64'(drop), 64'd1);
        @(posedge clk_ref); #1;
        chk("drop_clear", 64'(drop), 64'd0);
        drain();
        repeat (3) @(negedge clk_ref);
        chk("drop_count", 64'(drops), 64'd1);
        chk("valid_count", 64'(valids), 64'd1);

        valids = 0;
        send(32'd10_000_000, 32'd4_000_000, 32'd4_000_000, 1'b0, 1'b0, 66);
        repeat (30) @(posedge clk_ref);
        #3;
        sys_rst = 1'b1;
        sb.delete();
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_out", 64'({freq_valid, overflow, div_err, drop, freq_out}), 64'd0);
        repeat (2) @(negedge clk_ref);
        sys_rst = 1'b0;
        repeat (80) @(negedge clk_ref);
        chk("no_valid_after_abort", 64'(valids), 64'd0);
        send(32'd10_000_000, 32'd3_000_000, 32'd3_000_000, 1'b0, 1'b0, 66);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
